// File: rtl/alu_pipe.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add unsigned multiplier, behind a valid/ready handshake.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             set
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [SHW-1:0]     count;
  logic               accept, is_mul, mul_last;

  logic [WIDTH-1:0]   b_eff, sum, alu_res, step_add;
  logic [WIDTH:0]     sum_full, step_sum;
  logic [2*WIDTH-1:0] step_next;
  logic               carry, ovf, lt, alu_cout, alu_ovf, alu_set;
  logic [SHW-1:0]     shamt;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign mul_last = (state == BUSY) && (count == '0);
  assign shamt    = b[SHW-1:0];

  // One shared adder: subtraction and SLT use a + ~b + 1.
  always_comb begin
    b_eff    = (op == OP_ADD) ? b : ~b;
    sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op != OP_ADD)};
    sum      = sum_full[WIDTH-1:0];
    carry    = sum_full[WIDTH];
    ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt       = sum[WIDTH-1] ^ ovf;
  end

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_set  = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res  = sum;
        alu_cout = carry;
        alu_ovf  = ovf;
      end
      OP_SUB: begin
        alu_res  = sum;
        alu_cout = carry;
        alu_ovf  = ovf;
        alu_set  = lt;
      end
      OP_SLT: begin
        alu_res  = {{(WIDTH-1){1'b0}}, lt};
        alu_cout = carry;
        alu_set  = lt;
      end
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_MUL: alu_res = '0;
    endcase
  end

  // Shift-add step: the product's low half shifts into the multiplier register.
  always_comb begin
    step_add  = mplier[0] ? mcand : '0;
    step_sum  = {1'b0, acc} + {1'b0, step_add};
    step_next = {step_sum, mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul) state_next = BUSY;
      BUSY: if (count == '0)      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (accept && is_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= SHW'(WIDTH-1);
    end else if (state == BUSY) begin
      {acc, mplier} <= step_next;
      count         <= count - SHW'(1);
    end
  end

  // Output registers only move on a write or a drain, so they hold under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      set       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= alu_res;
      result_hi <= '0;
      cout      <= alu_cout;
      overflow  <= alu_ovf;
      zero      <= (alu_res == '0);
      set       <= alu_set;
      out_valid <= 1'b1;
    end else if (mul_last) begin
      result    <= step_next[WIDTH-1:0];
      result_hi <= step_next[2*WIDTH-1:WIDTH];
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= (step_next[WIDTH-1:0] == '0);
      set       <= 1'b0;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, literal expectations and a
// queue-based arithmetic model compared against every output on every cycle.
module tb_alu_pipe;

  localparam int W = 16;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_ready, out_valid, cout, overflow, zero, set;
  logic [W-1:0] result, result_hi;

  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         set;
    int           avail;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
  } vec_t;

  exp_t q[$];
  exp_t held;
  int   cyc = 0;
  vec_t vecs[10];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .cout(cout), .overflow(overflow), .zero(zero), .set(set)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t clearExp();
    exp_t e;
    e.res = '0; e.hi = '0; e.cout = 1'b0; e.ovf = 1'b0;
    e.zero = 1'b0; e.set = 1'b0; e.avail = 0;
    return e;
  endfunction

  // Result of one operation from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    exp_t        e;
    int          sx, sy, sr;
    int unsigned ux, uy;
    logic [31:0] wide;
    logic [3:0]  amt;
    e   = clearExp();
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    ux  = 32'(x);
    uy  = 32'(y);
    amt = y[3:0];
    case (o)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_ADD: begin
        wide   = ux + uy;
        e.res  = wide[15:0];
        e.cout = wide[16];
        sr     = sx + sy;
        e.ovf  = (sr > 32767) || (sr < -32768);
      end
      OP_SUB: begin
        e.res  = x - y;
        e.cout = (ux >= uy);
        sr     = sx - sy;
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.set  = (sx < sy);
      end
      OP_SLT: begin
        e.set  = (sx < sy);
        e.res  = e.set ? 16'd1 : 16'd0;
        e.cout = (ux >= uy);
      end
      OP_MUL: begin
        wide  = ux * uy;
        e.res = wide[15:0];
        e.hi  = wide[31:16];
      end
      OP_SLL: e.res = x << amt;
      OP_SRL: e.res = x >> amt;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Model bookkeeping: drains and accepts at each rising edge.
  initial begin
    bit   vis, rdy;
    exp_t e;
    held = clearExp();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        held = clearExp();
        cyc  = 0;
      end else begin
        vis = 1'b0;
        if (q.size() > 0) vis = (q[0].avail <= cyc);
        rdy = (q.size() == 0 || vis) && (!vis || out_ready);
        if (vis && out_ready) begin
          held = q[0];
          void'(q.pop_front());
        end
        cyc++;
        if (in_valid && rdy) begin
          e = model(a, b, op);
          e.avail = (op == OP_MUL) ? cyc + W : cyc;
          q.push_back(e);
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  initial begin
    bit   vis, busy;
    exp_t cur;
    forever begin
      @(negedge clk);
      vis  = 1'b0;
      busy = 1'b0;
      if (q.size() > 0) begin
        vis  = (q[0].avail <= cyc);
        busy = !vis;
      end
      cur = vis ? q[0] : held;
      checkOutput("out_valid", 32'(out_valid), 32'(vis));
      checkOutput("in_ready", 32'(in_ready), 32'(!busy && (!vis || out_ready)));
      checkOutput("result", 32'(result), 32'(cur.res));
      checkOutput("result_hi", 32'(result_hi), 32'(cur.hi));
      checkOutput("cout", 32'(cout), 32'(cur.cout));
      checkOutput("overflow", 32'(overflow), 32'(cur.ovf));
      checkOutput("zero", 32'(zero), 32'(cur.zero));
      checkOutput("set", 32'(set), 32'(cur.set));
    end
  end

  // Present one beat and hold it until it is taken; called just after a falling edge.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [2:0] vo, output int waits);
    bit done;
    a = va; b = vb; op = vo; in_valid = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 200) begin
      #1;
      done = in_ready;
      @(negedge clk); #1;
      if (!done) waits++;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!out_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w, n, rdy_hi;
    vecs[0] = '{16'hF0F0, 16'hFF00, OP_AND, 16'hF000};
    vecs[1] = '{16'h00F0, 16'h0F00, OP_OR,  16'h0FF0};
    vecs[2] = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000};
    vecs[3] = '{16'h0003, 16'h0005, OP_SUB, 16'hFFFE};
    vecs[4] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF};
    vecs[5] = '{16'h0001, 16'h8000, OP_SLT, 16'h0000};
    vecs[6] = '{16'hA5A5, 16'h0010, OP_SLL, 16'hA5A5};
    vecs[7] = '{16'hF000, 16'h0024, OP_SRL, 16'h0F00};
    vecs[8] = '{16'h0003, 16'h0005, OP_MUL, 16'h000F};
    vecs[9] = '{16'h1234, 16'h0000, OP_MUL, 16'h0000};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);

    $display("[TB] add overflow");
    applyStimulus(16'h7FFF, 16'h0001, OP_ADD, w);
    checkOutput("add_result", 32'(result), 32'h8000);
    checkOutput("add_overflow", 32'(overflow), 32'd1);
    checkOutput("add_cout", 32'(cout), 32'd0);
    checkOutput("add_zero", 32'(zero), 32'd0);
    checkOutput("add_set", 32'(set), 32'd0);

    applyStimulus(16'h0005, 16'h0005, OP_SUB, w);
    checkOutput("sub_result", 32'(result), 32'h0000);
    checkOutput("sub_zero", 32'(zero), 32'd1);
    checkOutput("sub_cout", 32'(cout), 32'd1);

    applyStimulus(16'h8000, 16'h0001, OP_SLT, w);
    checkOutput("slt_result", 32'(result), 32'h0001);
    checkOutput("slt_set", 32'(set), 32'd1);
    checkOutput("slt_overflow", 32'(overflow), 32'd0);

    $display("[TB] multiply latency");
    applyStimulus(16'hFFFF, 16'hFFFF, OP_MUL, w);
    n = 0;
    rdy_hi = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_hi++;
      @(negedge clk); #1;
      n++;
    end
    checkOutput("mul_latency", 32'(n), 32'd16);
    checkOutput("mul_in_ready_high", 32'(rdy_hi), 32'd0);
    checkOutput("mul_result", 32'(result), 32'h0001);
    checkOutput("mul_result_hi", 32'(result_hi), 32'hFFFE);

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'(i * 3 + 1), 16'(i + 100), OP_ADD, w);
      checkOutput("stream_bubble", 32'(w), 32'd0);
    end
    a = 16'h1234; b = 16'h1111; op = OP_ADD; in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("freeze_in_ready", 32'(in_ready), 32'd0);
      checkOutput("freeze_result", 32'(result), 32'h0079);
      checkOutput("freeze_valid", 32'(out_valid), 32'd1);
      @(negedge clk); #2;
    end
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h1111, OP_ADD, w);
    checkOutput("after_freeze_result", 32'(result), 32'h2345);

    $display("[TB] shifts");
    applyStimulus(16'h0001, 16'hFFF4, OP_SLL, w);
    checkOutput("sll_result", 32'(result), 32'h0010);
    applyStimulus(16'h8000, 16'h000F, OP_SRL, w);
    checkOutput("srl_result", 32'(result), 32'h0001);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, w);
      waitValid(n);
      checkOutput("vector_result", 32'(result), 32'(vecs[i].res));
    end

    $display("[TB] reset during multiply");
    applyStimulus(16'h0003, 16'h0005, OP_MUL, w);
    repeat (4) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_mul_result", 32'(result), 32'd0);
      checkOutput("rst_mul_result_hi", 32'(result_hi), 32'd0);
      checkOutput("rst_mul_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_mul_zero", 32'(zero), 32'd0);
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'd2, 16'd3, OP_ADD, w);
    checkOutput("post_rst_add", 32'(result), 32'd5);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
